// File: rtl/stc_timing_error_detector_pkg.sv
// Shared widths, the sample phase type and the TED saturation helper
// used by the STC timing error detector and its lock detector.
package stc_timing_error_detector_pkg;

    localparam int SAMPLE_W  = 18;
    localparam int DIFF_W    = SAMPLE_W + 1;
    localparam int PROD_W    = SAMPLE_W + DIFF_W;
    localparam int ERR_SUM_W = PROD_W + 1;
    localparam int TED_SHIFT = 20;
    localparam int TED_W     = 16;
    localparam int ERR_W     = 9;
    localparam int CNT_W     = 8;

    typedef enum logic {
        PH_ONTIME = 1'b0,
        PH_MID    = 1'b1
    } phase_e;

    // The shifted value fits TED_W bits only when all bits above the TED sign bit
    // are copies of it; otherwise clamp toward the sign of the full sum.
    function automatic logic signed [TED_W-1:0] tedSaturate(input logic signed [ERR_SUM_W-1:0] errSum);
        logic signed [ERR_SUM_W-1:0] shifted;
        shifted = errSum >>> TED_SHIFT;
        if (shifted[ERR_SUM_W-1:TED_W-1] == '0 || shifted[ERR_SUM_W-1:TED_W-1] == '1)
            return shifted[TED_W-1:0];
        else if (shifted[ERR_SUM_W-1])
            return {1'b1, {(TED_W-1){1'b0}}};
        else
            return {1'b0, {(TED_W-1){1'b1}}};
    endfunction

endpackage

// File: rtl/stc_lock_detector.sv
// Timing lock indicator: hysteresis on consecutive good/bad averaged
// timing-error dumps.
module stc_lock_detector
    import stc_timing_error_detector_pkg::*;
#(
    parameter int LOCK_TOL   = 4,
    parameter int LOCK_COUNT = 8
)(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    dumpEn,
    input  logic signed [ERR_W-1:0] dumpErr,
    output logic                    locked
);

    logic [CNT_W-1:0] goodCnt_q, goodCnt_d;
    logic [CNT_W-1:0] badCnt_q, badCnt_d;
    logic             locked_q, locked_d;
    logic [ERR_W:0]   errExt, errMag;
    logic             isGood;

    // One extra bit keeps |-256| representable.
    always_comb begin
        errExt    = {dumpErr[ERR_W-1], dumpErr};
        errMag    = dumpErr[ERR_W-1] ? (~errExt + (ERR_W+1)'(1)) : errExt;
        isGood    = errMag < (ERR_W+1)'(LOCK_TOL);
        goodCnt_d = goodCnt_q;
        badCnt_d  = badCnt_q;
        locked_d  = locked_q;
        if (dumpEn) begin
            if (isGood) begin
                goodCnt_d = (goodCnt_q == '1) ? goodCnt_q : goodCnt_q + CNT_W'(1);
                badCnt_d  = '0;
                if (goodCnt_d >= CNT_W'(LOCK_COUNT))
                    locked_d = 1'b1;
            end else begin
                badCnt_d  = (badCnt_q == '1) ? badCnt_q : badCnt_q + CNT_W'(1);
                goodCnt_d = '0;
                if (badCnt_d >= CNT_W'(LOCK_COUNT))
                    locked_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            goodCnt_q <= '0;
            badCnt_q  <= '0;
            locked_q  <= 1'b0;
        end else begin
            goodCnt_q <= goodCnt_d;
            badCnt_q  <= badCnt_d;
            locked_q  <= locked_d;
        end
    end

    assign locked = locked_q;

endmodule

// File: rtl/stc_timing_error_detector.sv
// Gardner timing error detector for the 2-samples/symbol STC stream: block-averaged
// sample-rate error for the resampler loop, on-time symbols and a lock flag.
module stc_timing_error_detector
    import stc_timing_error_detector_pkg::*;
#(
    parameter int AVG_LOG2   = 4,
    parameter int LOCK_TOL   = 4,
    parameter int LOCK_COUNT = 8
)(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clkEn,
    input  logic signed [SAMPLE_W-1:0] iIn,
    input  logic signed [SAMPLE_W-1:0] qIn,
    output logic                       symEn,
    output logic signed [SAMPLE_W-1:0] iSym,
    output logic signed [SAMPLE_W-1:0] qSym,
    output logic                       sampleRateErrorEn,
    output logic signed [ERR_W-1:0]    sampleRateError,
    output logic                       locked
);

    localparam int ACC_W = TED_W + AVG_LOG2;

    phase_e                      phase_q;
    logic                        seenOn_q;
    logic                        symEn_q;
    logic                        capV_q, prodV_q, tedV_q;
    logic signed [SAMPLE_W-1:0]  prevOnI_q, prevOnQ_q, midI_q, midQ_q, curOnI_q, curOnQ_q;
    logic signed [DIFF_W-1:0]    diffI_d, diffQ_d;
    logic signed [PROD_W-1:0]    prodI_d, prodQ_d, prodI_q, prodQ_q;
    logic signed [ERR_SUM_W-1:0] errSum_d;
    logic signed [TED_W-1:0]     ted_q;
    logic signed [ACC_W-1:0]     acc_q, accNext_d;
    logic [AVG_LOG2-1:0]         symCnt_q;
    logic                        dumpEn_d;
    logic signed [ERR_W-1:0]     dumpErr_d;
    logic                        errEn_q;
    logic signed [ERR_W-1:0]     err_q;

    // Capture stage; an error token is only issued once a previous on-time sample exists.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_q   <= PH_ONTIME;
            seenOn_q  <= 1'b0;
            symEn_q   <= 1'b0;
            capV_q    <= 1'b0;
            prevOnI_q <= '0;
            prevOnQ_q <= '0;
            midI_q    <= '0;
            midQ_q    <= '0;
            curOnI_q  <= '0;
            curOnQ_q  <= '0;
        end else begin
            symEn_q <= 1'b0;
            capV_q  <= 1'b0;
            if (clkEn) begin
                if (phase_q == PH_ONTIME) begin
                    prevOnI_q <= curOnI_q;
                    prevOnQ_q <= curOnQ_q;
                    curOnI_q  <= iIn;
                    curOnQ_q  <= qIn;
                    symEn_q   <= 1'b1;
                    seenOn_q  <= 1'b1;
                    capV_q    <= seenOn_q;
                    phase_q   <= PH_MID;
                end else begin
                    midI_q  <= iIn;
                    midQ_q  <= qIn;
                    phase_q <= PH_ONTIME;
                end
            end
        end
    end

    always_comb begin
        diffI_d  = DIFF_W'(prevOnI_q) - DIFF_W'(curOnI_q);
        diffQ_d  = DIFF_W'(prevOnQ_q) - DIFF_W'(curOnQ_q);
        prodI_d  = PROD_W'(midI_q) * PROD_W'(diffI_d);
        prodQ_d  = PROD_W'(midQ_q) * PROD_W'(diffQ_d);
        errSum_d = ERR_SUM_W'(prodI_q) + ERR_SUM_W'(prodQ_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prodV_q <= 1'b0;
            tedV_q  <= 1'b0;
            prodI_q <= '0;
            prodQ_q <= '0;
            ted_q   <= '0;
        end else begin
            prodV_q <= capV_q;
            tedV_q  <= prodV_q;
            if (capV_q) begin
                prodI_q <= prodI_d;
                prodQ_q <= prodQ_d;
            end
            if (prodV_q)
                ted_q <= tedSaturate(errSum_d);
        end
    end

    // The arithmetic shift by AVG_LOG2+7 leaves exactly the top ERR_W accumulator bits.
    always_comb begin
        accNext_d = acc_q + ACC_W'(ted_q);
        dumpEn_d  = tedV_q && (symCnt_q == '1);
        dumpErr_d = accNext_d[ACC_W-1 -: ERR_W];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q    <= '0;
            symCnt_q <= '0;
            errEn_q  <= 1'b0;
            err_q    <= '0;
        end else begin
            errEn_q <= dumpEn_d;
            if (tedV_q) begin
                if (dumpEn_d) begin
                    acc_q    <= '0;
                    symCnt_q <= '0;
                    err_q    <= dumpErr_d;
                end else begin
                    acc_q    <= accNext_d;
                    symCnt_q <= symCnt_q + AVG_LOG2'(1);
                end
            end
        end
    end

    stc_lock_detector #(
        .LOCK_TOL   (LOCK_TOL),
        .LOCK_COUNT (LOCK_COUNT)
    ) u_lock (
        .clk     (clk),
        .reset   (reset),
        .dumpEn  (dumpEn_d),
        .dumpErr (dumpErr_d),
        .locked  (locked)
    );

    assign symEn             = symEn_q;
    assign iSym              = curOnI_q;
    assign qSym              = curOnQ_q;
    assign sampleRateErrorEn = errEn_q;
    assign sampleRateError   = err_q;

endmodule

// File: doc/stc_timing_error_detector.md
# stc_timing_error_detector

Gardner symbol-timing error detector and timing-lock indicator for the STC receive path. Consumes the 2-samples/symbol resampled stream (iStc/qStc with resampSync) from the STC downconverter, averages the per-symbol timing error over a block of symbols, and returns a signed 9-bit sampleRateError with enable pulse that closes the resampler loop. Also emits on-time symbol samples and a timing `locked` flag, which freezes the narrowband channel AGC.

## Interface
- AVG_LOG2, 4: log2 of symbols averaged per error dump (1..8).
- LOCK_TOL, 4: |sampleRateError| strictly below this counts as a "good" dump.
- LOCK_COUNT, 8: consecutive good (bad) dumps needed to assert (deassert) `locked`; 1..255.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- clkEn  in  1  sample strobe from resampler (resampSync); two strobes per symbol.
- iIn, qIn  in  18 signed  resampled I/Q (iStc/qStc), valid when clkEn.
- symEn  out  1  one-cycle strobe, on-time symbol available.
- iSym, qSym  out  18 signed  on-time symbol samples, held between symEn.
- sampleRateErrorEn  out  1  one-cycle strobe, new averaged error.
- sampleRateError  out  9 signed  averaged timing error, held between strobes.
- locked  out  1  timing lock indicator.

## Operation
- `phase` toggles on each clkEn; phase 0 = on-time sample, phase 1 = mid sample. Reset → phase 0.
- Registers: prevOn, mid, curOn (I and Q). Mid sample stores to mid; on-time sample shifts curOn→prevOn, input→curOn.
- `primed` sets on the second on-time sample after reset; no error computed before it.
- Per on-time sample (when primed): dI = prevOn.I − curOn.I, dQ likewise (19-bit signed); e = mid.I·dI + mid.Q·dQ (38-bit signed); ted = e >>> 20 (arithmetic), saturated to 16-bit signed [−32768, 32767].
- Accumulator (16+AVG_LOG2 bits signed) adds ted; symbol counter counts 0..2^AVG_LOG2−1. On the terminal count: sampleRateError = (acc + ted) >>> (AVG_LOG2+7), fits 9 bits without saturation; strobe sampleRateErrorEn; accumulator reloads 0.
- Lock: goodCnt/badCnt (8-bit). On each dump, good if |sampleRateError| < LOCK_TOL: goodCnt++ (saturating), badCnt=0; else badCnt++, goodCnt=0. locked sets when goodCnt reaches LOCK_COUNT, clears when badCnt reaches LOCK_COUNT; otherwise holds.
- Reset (async, any time incl. mid-block): all outputs 0, locked 0, phase 0, primed 0, accumulator/counters 0, sample registers 0. Block restarts cleanly after release.

## Timing
- symEn, iSym, qSym: registered, 1 cycle after on-time clkEn.
- Error pipeline: cycle 0 capture, cycle 1 dI/dQ and products registered, cycle 2 sum/shift/saturate registered, cycle 3 accumulate/dump. sampleRateErrorEn asserts 4 cycles after the on-time clkEn of the last symbol in a block.
- Pipeline is fully registered and accepts clkEn every cycle; no stalls, no back-pressure.
- locked updates in the same cycle as sampleRateErrorEn.
- clkEn low: all state holds; pipeline stages advance only on valid tokens.

## Structure
- Shared package: TED_SHIFT (20), TED_W (16), ERR_W (9), sample width (18).
- One natural sub-module: `stc_lock_detector` (good/bad counters, hysteresis, locked flag), driven by the dump strobe and error value.

## Test plan
- Reset: hold reset low, drive random clkEn/data → all outputs 0; release, no sampleRateErrorEn before 2^AVG_LOG2 + 1 on-time samples.
- Alternating symbols: on-time I = +65536/−65536, mid I = +8192/−8192 in matching sign, Q=0, AVG_LOG2=4 → ted = 1024 per symbol, sampleRateError = +8 every 16 symbols; negate mid → −8.
- Saturation: prevOn I=Q=131071, curOn I=Q=−131072, mid I=Q=131071 → ted saturates 32767, sampleRateError = +255.
- Lock hysteresis: constant I=50000 on all samples → error 0, locked asserts on 8th dump (128 symbols); then saturation stimulus → locked clears on 8th bad dump; one good dump interleaved resets badCnt.
- Back-to-back clkEn every cycle vs. spaced every 7 cycles, same data → identical error sequence; latency 4 cycles from last on-time clkEn.
- Reset asserted mid-block (symbol 9 of 16) → outputs 0 immediately; first dump after release uses only post-reset symbols.
